multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM that sequences the team's multicycle RV32I datapath (shared instruction/data memory port, single ALU, PC/IR/ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps. It supports lw, sw, R-type, I-type ALU, beq and jal. It stalls on a req/ready memory handshake. It flags unsupported opcodes without hanging the core.

## Interface
Parameters
- none (all encodings come from the shared package)

Ports
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode field of the instruction register
- zero  in  1  ALU zero flag, used in the beq compare cycle
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  memory write strobe, qualifies mem_req
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = use funct fields
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded combinationally from op in every state
- illegal_op  out  1  sticky flag: an unsupported opcode was decoded

## Operation
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state: lw/sw → MEMADR; R → EXECR; I-ALU → EXECI; beq → BEQ; jal → JAL.
  - Any other opcode: set illegal_op and go to FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, held stable while waiting. On mem_ready go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Go to ALUWB, which writes PC+4 to rd.
- illegal_op is cleared only by reset.

## Timing
- State register is asynchronously reset to FETCH.
- While rst_n=0, force mem_req, MemWrite, IRWrite, PCWrite, RegWrite and illegal_op to 0.
- After reset release, the first rising edge samples FETCH with mem_req=1.
- Outputs are functions of the state only, except:
  - IRWrite and PCWrite in FETCH are qualified by mem_ready.
  - PCWrite in BEQ is qualified by zero.
  - ImmSrc is decoded from op.
- Cycle counts with mem_ready tied high:
  - lw 5
  - sw 4
  - R-type / I-ALU 4
  - jal 4
  - beq 3
  - illegal 2
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in all states that do not assert mem_req.
- Request rules:
  - mem_req, AdrSrc and MemWrite stay stable from first assertion until the accepting cycle.
  - mem_req may deassert only after the cycle in which mem_ready=1 was sampled.
- Reset mid-access (rst_n falling during any state): drop mem_req and all write enables immediately (asynchronously). Resume in FETCH.
- op may change only on IRWrite. The FSM reads op in DECODE, MEMADR and later states, all of which follow the IR load.

## Structure
- Shared package `mc_ctrl_pkg` contains:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL)
  - opcode localparams
  - ResultSrc, ALUSrcA, ALUSrcB, ALUOp and ImmSrc encodings
- One sub-module, `imm_src_decode`: combinational op → ImmSrc plus an is_legal flag. It is shared with the decode stage of the planned pipelined core.
- The top module contains the state register, next-state logic, output decode and the illegal_op flop.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 → mem_req=0, all write enables 0, illegal_op=0. Release → FETCH, mem_req=1.
- lw (op=0000011), mem_ready=1 → states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. RegWrite=1 with ResultSrc=01 in cycle 5, then FETCH.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite, mem_req and AdrSrc=1 stable for 4 cycles. Return to FETCH after the ready cycle. RegWrite never 1.
- beq with zero=1, then repeated with zero=0 → PCWrite=1 in BEQ for zero=1; PCWrite=0 for zero=0. Both return to FETCH after 3 cycles.
- jal, then R-type (op=0110011) → jal: PCWrite=1 in JAL and RegWrite=1 in ALUWB. R-type: ALUOp=10 and ALUSrcB=00 in EXECR, 4 cycles total.
- op=1111111 → illegal_op rises after DECODE and stays 1 across following valid instructions. Asserting rst_n=0 mid-MEMREAD clears illegal_op and drops mem_req immediately.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and the datapath mux/ALU select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// plus memory port (slave).
interface multicycle_controller_if;

  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op
  );

endinterface

// File: rtl/multicycle_controller_imm_src_decode.sv
// Combinational opcode -> immediate format decode with a legality flag; reused
// by the decode stage of the pipelined core.
module imm_src_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src,
  output logic       is_legal
);

  // R-type has no immediate; it reports I so the extender output is harmless.
  always_comb begin
    imm_src  = IMM_I;
    is_legal = 1'b1;
    case (op)
      OP_LW, OP_IALU, OP_RTYPE: imm_src = IMM_I;
      OP_SW:                    imm_src = IMM_S;
      OP_BEQ:                   imm_src = IMM_B;
      OP_JAL:                   imm_src = IMM_J;
      default:                  is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the multicycle RV32I datapath through fetch,
// decode, execute, memory and writeback, stalling on the memory handshake.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t     state, state_next;
  logic       is_legal;
  logic [1:0] imm_src;
  logic       illegal_q;
  logic       mem_req, mem_write, irwrite, pcwrite, regwrite;

  imm_src_decode u_imm_src_decode (
    .op       (bus.op),
    .imm_src  (imm_src),
    .is_legal (is_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Sticky until reset so software-visible debug can see a bad opcode was skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         illegal_q <= 1'b0;
    else if (state == DECODE && !is_legal) illegal_q <= 1'b1;
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    bus.AdrSrc    = 1'b0;
    irwrite       = 1'b0;
    pcwrite       = 1'b0;
    regwrite      = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RD2;
    bus.ALUOp     = ALUOP_ADD;
    case (state)
      FETCH: begin
        mem_req       = 1'b1;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        if (bus.mem_ready) begin
          irwrite    = 1'b1;
          pcwrite    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut here.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_IALU:      state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        state_next  = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req    = 1'b1;
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        regwrite      = 1'b1;
        state_next    = FETCH;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_next = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_RD2;
        bus.ALUOp   = ALUOP_FUNCT;
        state_next  = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_FUNCT;
        state_next  = ALUWB;
      end
      ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        regwrite      = 1'b1;
        state_next    = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA   = SRCA_RD1;
        bus.ALUSrcB   = SRCB_RD2;
        bus.ALUOp     = ALUOP_SUB;
        bus.ResultSrc = RES_ALUOUT;
        pcwrite       = bus.zero;
        state_next    = FETCH;
      end
      JAL: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALUOUT;
        pcwrite       = 1'b1;
        state_next    = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  // The reset state is FETCH, so requests and strobes are gated by rst_n directly
  // to vanish the moment reset asserts rather than at the next edge.
  assign bus.mem_req    = mem_req   & rst_n;
  assign bus.MemWrite   = mem_write & rst_n;
  assign bus.IRWrite    = irwrite   & rst_n;
  assign bus.PCWrite    = pcwrite   & rst_n;
  assign bus.RegWrite   = regwrite  & rst_n;
  assign bus.ImmSrc     = imm_src;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a per-instruction
// behavioural model queues expected control words that a negedge monitor checks.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  snap_t      exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;
  int         instr_no = 0;
  logic [6:0] cur_op = OP_IALU;
  bit         ill_seen = 1'b0;
  logic [6:0] legal_ops [6] = '{OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit is_legal_op(input logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL};
  endfunction

  function automatic string op_name(input logic [6:0] o);
    case (o)
      OP_LW:    return "lw";
      OP_SW:    return "sw";
      OP_RTYPE: return "rtype";
      OP_IALU:  return "ialu";
      OP_BEQ:   return "beq";
      OP_JAL:   return "jal";
      default:  return "illegal";
    endcase
  endfunction

  // Everything low except the decoded immediate format and the sticky flag.
  function automatic snap_t quiet();
    snap_t s;
    s         = '0;
    s.imm_src = imm_of(cur_op);
    s.illegal = ill_seen;
    return s;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input snap_t e, input string n, input logic ready, input logic z);
    bus.mem_ready = ready;
    bus.zero      = z;
    bus.op        = cur_op;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] new_op, input int fetch_waits, input int mem_waits,
                               input logic z, input bit abort_at_mem);
    snap_t e;
    string tag;
    instr_no++;
    tag = $sformatf("%s#%0d", op_name(new_op), instr_no);

    e            = quiet();
    e.mem_req    = 1'b1;
    e.alu_src_b  = 2'b10;
    e.result_src = 2'b10;
    for (int w = 0; w < fetch_waits; w++) step(e, {tag, " fetch-wait"}, 1'b0, rnd_bit());
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    step(e, {tag, " fetch"}, 1'b1, rnd_bit());

    cur_op      = new_op;
    e           = quiet();
    e.alu_src_a = 2'b01;
    e.alu_src_b = 2'b01;
    step(e, {tag, " decode"}, rnd_bit(), rnd_bit());
    if (!is_legal_op(new_op)) begin
      ill_seen = 1'b1;
      return;
    end

    if (new_op == OP_LW || new_op == OP_SW) begin
      e           = quiet();
      e.alu_src_a = 2'b10;
      e.alu_src_b = 2'b01;
      step(e, {tag, " address"}, rnd_bit(), rnd_bit());
      if (abort_at_mem) return;
      e           = quiet();
      e.mem_req   = 1'b1;
      e.adr_src   = 1'b1;
      e.mem_write = (new_op == OP_SW);
      for (int w = 0; w < mem_waits; w++) step(e, {tag, " mem-wait"}, 1'b0, rnd_bit());
      step(e, {tag, " mem-accept"}, 1'b1, rnd_bit());
      if (new_op == OP_LW) begin
        e            = quiet();
        e.result_src = 2'b01;
        e.reg_write  = 1'b1;
        step(e, {tag, " load-writeback"}, rnd_bit(), rnd_bit());
      end
    end else if (new_op == OP_BEQ) begin
      e           = quiet();
      e.alu_src_a = 2'b10;
      e.alu_op    = 2'b01;
      e.pc_write  = z;
      step(e, {tag, " compare"}, rnd_bit(), z);
    end else begin
      e = quiet();
      if (new_op == OP_JAL) begin
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b10;
        e.pc_write  = 1'b1;
      end else begin
        e.alu_src_a = 2'b10;
        e.alu_src_b = (new_op == OP_IALU) ? 2'b01 : 2'b00;
        e.alu_op    = 2'b10;
      end
      step(e, {tag, " execute"}, rnd_bit(), rnd_bit());
      e           = quiet();
      e.reg_write = 1'b1;
      step(e, {tag, " writeback"}, rnd_bit(), rnd_bit());
    end
  endtask

  always @(negedge clk) begin
    snap_t e;
    snap_t a;
    string n;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal_op};
      checkOutput(n, 32'(a), 32'(e));
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] strobes();
    return {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.illegal_op};
  endfunction

  initial begin
    logic [6:0] o;
    bus.op        = OP_IALU;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset strobes", 32'(strobes()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(OP_LW, 0, 0, 1'b0, 1'b0);
    applyStimulus(OP_SW, 0, 3, 1'b0, 1'b0);
    applyStimulus(OP_BEQ, 0, 0, 1'b1, 1'b0);
    applyStimulus(OP_BEQ, 0, 0, 1'b0, 1'b0);
    applyStimulus(OP_JAL, 0, 0, 1'b0, 1'b0);
    applyStimulus(OP_RTYPE, 0, 0, 1'b0, 1'b0);
    applyStimulus(7'b1111111, 0, 0, 1'b0, 1'b0);
    applyStimulus(OP_IALU, 2, 0, 1'b0, 1'b0);
    applyStimulus(OP_LW, 1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) o = 7'($urandom);
      else                           o = legal_ops[$urandom_range(0, 5)];
      applyStimulus(o, $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit(), 1'b0);
    end

    // Asynchronous reset in the middle of a stalled load read.
    applyStimulus(7'b1111111, 0, 0, 1'b0, 1'b0);
    applyStimulus(OP_LW, 0, 0, 1'b0, 1'b1);
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("memread before reset {req,adr,illegal}",
                32'({bus.mem_req, bus.AdrSrc, bus.illegal_op}), 32'(3'b111));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid-memread reset strobes", 32'(strobes()), 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("held reset strobes", 32'(strobes()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ill_seen = 1'b0;

    applyStimulus(OP_SW, 1, 1, 1'b0, 1'b0);
    applyStimulus(OP_BEQ, 0, 0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
